// File: rtl/tx_ctrl_pkg.sv
// tx_ctrl_pkg: shared widths, FSM state encoding and helpers for the UART transmit sequencer.
// Contents: BYTE_W/WORD_W widths, tx_state_t state enum, is_wait() wait-state classifier.
package tx_ctrl_pkg;
   localparam int BYTE_W = 8;
   localparam int WORD_W = 16;
   typedef enum logic [3:0] {
      S_IDLE, S_SEND_0, S_ACK_0, S_DONE_0, S_DELAY, S_SEND_1, S_ACK_1, S_DONE_1, S_FINISH
   } tx_state_t;
   // States that block on the UART busy handshake (watchdog-supervised when enabled)
   function automatic logic is_wait(input tx_state_t s);
      return s inside {S_ACK_0, S_DONE_0, S_ACK_1, S_DONE_1};
   endfunction
endpackage

// File: rtl/inter_byte_timer.sv
// inter_byte_timer: loadable down-counter that stops at zero and flags it.
// Ports: clock, reset (sync, active-high); i_load/i_load_val reload the count;
//        i_en decrements while non-zero; o_zero is high when the count is zero.
module inter_byte_timer #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_zero
);
   logic [W-1:0] r_count;
   always_ff @(posedge clock) begin
      if (reset)
         r_count <= '0;
      else if (i_load)
         r_count <= i_load_val;
      else if (i_en && r_count != '0)
         r_count <= r_count - 1'b1;
   end
   assign o_zero = r_count == '0;
endmodule

// File: rtl/tx_control.sv
// tx_control: sends one 16-bit word to a byte-wide UART TX driver as one byte
// (low) or two bytes (high first, then low), with an inter-byte idle gap.
// Ports: clock, reset (sync, active-high); i_tx_data/i_send16 captured when
//        i_tx_start is accepted in IDLE; i_uart_busy from the UART driver;
//        o_uart_data/o_uart_start drive the UART; o_busy spans the transfer;
//        o_done pulses on completion; o_timeout_err pulses on watchdog abort.
// Build option: define TX_CTRL_TIMEOUT_EN to enable the wait-state watchdog;
//        otherwise o_timeout_err is tied low and waits are unbounded.
module tx_control
   import tx_ctrl_pkg::*;
#(
   parameter int INTER_DELAY_CYCLES = 16,
   parameter int TIMEOUT_CYCLES     = 100000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [WORD_W-1:0] i_tx_data,
   input  logic              i_tx_start,
   input  logic              i_send16,
   input  logic              i_uart_busy,
   output logic [BYTE_W-1:0] o_uart_data,
   output logic              o_uart_start,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_timeout_err
);
   localparam int DLY_W = INTER_DELAY_CYCLES > 0 ? $clog2(INTER_DELAY_CYCLES + 1) : 1;
   // Loaded with N-1 so DELAY occupies exactly N clocks before SEND_1
   localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(INTER_DELAY_CYCLES > 0 ? INTER_DELAY_CYCLES - 1 : 0);

   if (INTER_DELAY_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("tx_control: INTER_DELAY_CYCLES must be >= 0 and TIMEOUT_CYCLES >= 1");
   end

   tx_state_t         r_state, w_next;
   logic [WORD_W-1:0] r_word, w_word;
   logic              r_send16, w_send16;
   logic [BYTE_W-1:0] r_uart_data, w_uart_data;
   logic              r_uart_start, w_uart_start;
   logic              r_busy, w_busy;
   logic              r_done, w_done;
   logic              w_dly_load, w_dly_zero;

   inter_byte_timer #(.W(DLY_W)) u_delay (
      .clock      (clock),
      .reset      (reset),
      .i_load     (w_dly_load),
      .i_load_val (DLY_LOAD),
      .i_en       (r_state == S_DELAY),
      .o_zero     (w_dly_zero)
   );

`ifdef TX_CTRL_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic r_timeout_err, w_timeout_err, w_wd_load, w_wd_zero;
   inter_byte_timer #(.W(TO_W)) u_watchdog (
      .clock      (clock),
      .reset      (reset),
      .i_load     (w_wd_load),
      .i_load_val (TO_W'(TIMEOUT_CYCLES - 1)),
      .i_en       (is_wait(r_state)),
      .o_zero     (w_wd_zero)
   );
`endif

   always_comb begin
      w_next       = r_state;
      w_word       = r_word;
      w_send16     = r_send16;
      w_uart_data  = r_uart_data;
      w_uart_start = 1'b0;
      w_busy       = r_busy;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: if (i_tx_start) begin
            w_word   = i_tx_data;
            w_send16 = i_send16;
            w_busy   = 1'b1;
            w_next   = S_SEND_0;
         end
         S_SEND_0: begin
            w_uart_data  = r_send16 ? r_word[15:8] : r_word[7:0];
            w_uart_start = 1'b1;
            w_next       = S_ACK_0;
         end
         S_ACK_0:  w_next = i_uart_busy ? S_DONE_0 : S_ACK_0;
         S_DONE_0: if (!i_uart_busy)
            w_next = !r_send16 ? S_FINISH : INTER_DELAY_CYCLES != 0 ? S_DELAY : S_SEND_1;
         S_DELAY:  w_next = w_dly_zero ? S_SEND_1 : S_DELAY;
         S_SEND_1: begin
            w_uart_data  = r_word[7:0];
            w_uart_start = 1'b1;
            w_next       = S_ACK_1;
         end
         S_ACK_1:  w_next = i_uart_busy ? S_DONE_1 : S_ACK_1;
         S_DONE_1: w_next = i_uart_busy ? S_DONE_1 : S_FINISH;
         S_FINISH: begin
            w_done = 1'b1;
            w_busy = 1'b0;
            w_next = S_IDLE;
         end
         default:  w_next = S_IDLE;
      endcase
`ifdef TX_CTRL_TIMEOUT_EN
      // A normal handshake step on the expiry clock wins over the abort
      w_timeout_err = 1'b0;
      if (is_wait(r_state) && w_wd_zero && w_next == r_state) begin
         w_timeout_err = 1'b1;
         w_busy        = 1'b0;
         w_next        = S_IDLE;
      end
      w_wd_load = is_wait(w_next) && w_next != r_state;
`endif
      w_dly_load = r_state == S_DONE_0 && w_next == S_DELAY;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_word       <= '0;
         r_send16     <= 1'b0;
         r_uart_data  <= '0;
         r_uart_start <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_word       <= w_word;
         r_send16     <= w_send16;
         r_uart_data  <= w_uart_data;
         r_uart_start <= w_uart_start;
         r_busy       <= w_busy;
         r_done       <= w_done;
      end
   end

`ifdef TX_CTRL_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (reset)
         r_timeout_err <= 1'b0;
      else
         r_timeout_err <= w_timeout_err;
   end
   assign o_timeout_err = r_timeout_err;
`else
   assign o_timeout_err = 1'b0;
`endif

   assign o_uart_data  = r_uart_data;
   assign o_uart_start = r_uart_start;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
endmodule
